// File: rtl/dmem_bridge.sv
// ============================================================================
//  Module   : dmem_bridge
//  Summary  : Turns the CPU's zero-wait data-memory access into a req/ack
//             transaction on a shared bus. It stalls the CPU until the access
//             completes, forces completion on a bus timeout and records that
//             timeout in a sticky error flag.
//             Define DMEM_RDCACHE_EN to add a one-entry read buffer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_bridge #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        err_sticky
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        w_hit;
    logic        w_timeout;
    logic        w_unused_addr_lsbs;

    // Word access: the byte-lane bits of the address are intentionally dropped.
    assign w_unused_addr_lsbs = &{1'b0, cpu_addr[1:0]};
    assign w_timeout          = (r_cnt == c_cnt_last);

`ifdef DMEM_RDCACHE_EN
    logic        r_buf_valid;
    logic [29:0] r_buf_tag;
    logic [31:0] r_buf_data;

    assign w_hit     = (r_state == IDLE) && cpu_re && !cpu_we && r_buf_valid &&
                       (r_buf_tag == cpu_addr[31:2]);
    assign cpu_rdata = w_hit ? r_buf_data : r_rdata;

    // Buffer is write-through; a store of unknown outcome makes it untrustworthy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
        end else if (r_state == BUSY) begin
            if (bus_ack) begin
                if (!bus_we) begin
                    r_buf_valid <= 1'b1;
                    r_buf_tag   <= bus_addr[31:2];
                    r_buf_data  <= bus_rdata;
                end else if (r_buf_valid && (r_buf_tag == bus_addr[31:2])) begin
                    r_buf_data  <= bus_wdata;
                end
            end else if (w_timeout && bus_we) begin
                r_buf_valid <= 1'b0;
            end
        end
    end
`else
    assign w_hit     = 1'b0;
    assign cpu_rdata = r_rdata;
`endif

    assign cpu_stall = !reset &&
                       (((r_state == IDLE) && (cpu_re || cpu_we) && !w_hit) ||
                        (r_state == BUSY));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            r_rdata    <= '0;
            err_sticky <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if ((cpu_re || cpu_we) && !w_hit) begin
                        bus_req   <= 1'b1;
                        bus_we    <= cpu_we;
                        bus_addr  <= {cpu_addr[31:2], 2'b00};
                        bus_wdata <= cpu_wdata;
                        r_cnt     <= '0;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        if (!bus_we) begin
                            r_rdata <= bus_rdata;
                        end
                        bus_req <= 1'b0;
                        r_state <= DONE;
                    end else if (w_timeout) begin
                        if (!bus_we) begin
                            r_rdata <= ERR_DATA;
                        end
                        bus_req    <= 1'b0;
                        err_sticky <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                // The request still visible here belongs to the retiring instruction.
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the single-cycle CPU datapath on its data-memory side.
- Consumes the address (ALUResult), store data (WriteData) and load/store strobes, and returns ReadData.
- Converts the zero-wait CPU access into a req/ack handshake on a slower shared data bus.
- Asserts a stall so the CPU holds PC and register writes until the access completes, with a bus timeout and error capture.

Parameters:
- TIMEOUT, 16, BUSY-state cycles without bus_ack before forced completion (legal range 2..255).
- ERR_DATA, 32'hDEAD_BEEF, value returned on cpu_rdata for a timed-out read.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cpu_re  input  1  load request (LDR), level, held stable while cpu_stall=1.
- cpu_we  input  1  store request (STR), level, held stable while cpu_stall=1.
- cpu_addr  input  32  byte address from ALUResult; bits [1:0] ignored (word access).
- cpu_wdata  input  32  store data from WriteData.
- cpu_rdata  output  32  load data to the result mux (ReadData).
- cpu_stall  output  1  CPU must not advance PC or write the register file this cycle.
- bus_req  output  1  bus request, registered.
- bus_we  output  1  1 = write cycle, registered.
- bus_addr  output  32  word-aligned address, {cpu_addr[31:2],2'b00}, registered.
- bus_wdata  output  32  write data, registered.
- bus_rdata  input  32  read data, valid in the bus_ack cycle.
- bus_ack  input  1  single-cycle completion strobe from the bus.
- err_sticky  output  1  set on any timeout; cleared only by reset.

Behaviour:
- Reset state is IDLE. While reset is asserted and after it is released, all registered outputs are 0: bus_req, bus_we, bus_addr, bus_wdata, cpu_rdata, err_sticky.
- cpu_stall is 0 while reset is asserted.
- cpu_stall is combinational: (state==IDLE && (cpu_re|cpu_we) && !hit) || state==BUSY.
- FSM states are IDLE, BUSY, DONE.
- IDLE with a request and no hit:
  - Latch addr, wdata and we; cpu_we has priority over cpu_re, so a simultaneous assertion is treated as a store.
  - Set bus_req=1 and go to BUSY. The counter is cleared.
- BUSY:
  - bus_req stays 1 and bus_addr/bus_we/bus_wdata stay stable until bus_ack.
  - On bus_ack: capture bus_rdata into cpu_rdata (reads only; writes leave cpu_rdata unchanged), drop bus_req, go to DONE.
  - If there is no ack and the counter reaches TIMEOUT-1: drop bus_req, set err_sticky, load ERR_DATA into cpu_rdata for a read, go to DONE.
  - bus_ack in any state other than BUSY is ignored.
- DONE:
  - cpu_stall=0 for exactly one cycle. The CPU commits the writeback/PC on this edge.
  - Next state is IDLE unconditionally. A request present in DONE is not re-issued, because it belongs to the instruction that just retired.
- cpu_rdata holds its value until the next read completion.
- Latency: with ack in the first BUSY cycle, a load or store stalls 2 cycles (IDLE, BUSY) and commits in the 3rd (DONE). Each ack delay cycle adds 1. A timeout stalls 1+TIMEOUT cycles.
- Reset mid-operation forces IDLE and deasserts bus_req immediately (asynchronously). The bus slave must tolerate an abandoned request.
- The counter is 8 bits and never wraps, because TIMEOUT ≤ 255.

Optional Feature:
- Macro DMEM_RDCACHE_EN enables a one-entry read buffer (valid, tag[31:2], data).
  - hit = cpu_re && !cpu_we && valid && tag==cpu_addr[31:2] in IDLE. On a hit: cpu_stall=0, cpu_rdata is driven combinationally from the buffer data, no bus cycle is issued, and the CPU commits in the same cycle.
  - A successful read fills the buffer; a timed-out read does not.
  - A completed write whose address equals the tag updates the buffer data (write-through). A write that times out clears valid.
  - valid is 0 after reset.
- Without the macro: hit is the constant 0, no buffer storage exists, and every access uses the bus.

Test Plan:
- Read 0x100, bus returns 0x12345678 with ack in the 1st BUSY cycle -> cpu_stall high 2 cycles; cpu_rdata=0x12345678 in DONE; bus_addr=0x100, bus_we=0.
- Store cpu_addr=0x203, wdata=0xA5A5A5A5, ack after 3 cycles -> bus_addr=0x200, bus_we=1, bus_wdata=0xA5A5A5A5 held stable for all 4 BUSY cycles; stall lasts 5 cycles; cpu_rdata unchanged.
- Read with bus_ack never asserted, TIMEOUT=16 -> bus_req drops after 16 BUSY cycles; cpu_rdata=0xDEADBEEF; err_sticky=1 and stays 1 through later good accesses.
- cpu_re=cpu_we=1 together -> bus_we=1 (store); assert reset during BUSY -> bus_req=0 the same cycle; all outputs 0; next request restarts cleanly.
- With DMEM_RDCACHE_EN: read 0x40 (bus returns 7), read 0x40 again -> cpu_stall=0, cpu_rdata=7, no bus_req; store 9 to 0x40, then read -> 9 with no bus cycle; read 0x44 -> normal bus access.
